// File: rtl/aes_key_schedule.sv
// Sequential AES-128/192/256 key expansion: one 32-bit schedule word per clock
// into a round-key store with a registered 128-bit random-access read port.

module s_box (
  input  logic [7:0] a_key,
  output logic [7:0] c_key
);
  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int k = 0; k < 8; k++) begin
      if (b[3'(k)]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  logic [7:0] sq;
  logic [7:0] inv;

  // Multiplicative inverse as a^254 (0 maps to 0), then the affine transform.
  always_comb begin
    sq  = a_key;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    c_key = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
            {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module aes_key_schedule #(
  parameter int MAX_KEY_BITS = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         key_ready,
  output logic         done,
  output logic         err,
  output logic [3:0]   num_rounds,
  input  logic [3:0]   rd_round,
  output logic [127:0] rd_key
);
  localparam int MAX_NK = MAX_KEY_BITS / 32;
  localparam int DEPTH  = 4 * (MAX_NK + 7);

  typedef enum logic {IDLE, EXPAND} state_t;
  state_t state;

  logic [31:0] store [DEPTH];
  logic [31:0] hist [8];      // hist[7] = w[i-1] ... hist[0] = w[i-8]
  logic [31:0] hist_load [8];
  logic [7:0][31:0] key_w;    // key_w[7] = w0

  logic [3:0] nk;
  logic [5:0] i_idx;
  logic [5:0] last_idx;
  logic [2:0] i_mod;
  logic [2:0] mod_last;
  logic [7:0] rcon;

  logic [3:0]  req_nk;
  logic        req_ok;
  logic        accept;
  logic [31:0] prev;
  logic [31:0] sub_in;
  logic [31:0] sub_out;
  logic [31:0] w_back;
  logic [31:0] temp;
  logic [31:0] new_w;
  logic [5:0]  rd_base;
  int          h_idx;

  assign key_w    = key_in;
  assign mod_last = nk[2:0] - 3'd1;  // nk = 8 wraps to 7
  assign rd_base  = {rd_round, 2'b00};

  always_comb begin
    req_nk = 4'd4 + {1'b0, key_len, 1'b0};
    req_ok = (key_len != 2'b11) && (int'(req_nk) <= MAX_NK);
    accept = (state == IDLE) && start && req_ok;
  end

  // Key words land right-aligned in the history window so hist[8-Nk] = w[i-Nk].
  always_comb begin
    h_idx = 0;
    for (int k = 0; k < 8; k++) begin
      h_idx = 15 - k - int'(req_nk);
      hist_load[3'(k)] = (h_idx >= 0 && h_idx <= 7) ? key_w[h_idx[2:0]] : 32'h0;
    end
  end

  assign prev   = hist[7];
  assign sub_in = (i_mod == 3'd0) ? {prev[23:0], prev[31:24]} : prev;

  for (genvar g = 0; g < 4; g++) begin : g_sub
    s_box u_s_box (
      .a_key(sub_in[8*g +: 8]),
      .c_key(sub_out[8*g +: 8])
    );
  end

  always_comb begin
    case (nk)
      4'd4:    w_back = hist[4];
      4'd6:    w_back = hist[2];
      default: w_back = hist[0];
    endcase
    if (i_mod == 3'd0)
      temp = sub_out ^ {rcon, 24'h0};
    else if (nk == 4'd8 && i_mod == 3'd4)
      temp = sub_out;
    else
      temp = prev;
    new_w = w_back ^ temp;
  end

  // Store and history are data only; their contents after reset are don't-care.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < 8; k++) store[6'(k)] <= key_w[3'(7 - k)];
      for (int k = 0; k < 8; k++) hist[3'(k)] <= hist_load[3'(k)];
    end else if (state == EXPAND) begin
      store[i_idx] <= new_w;
      for (int k = 0; k < 7; k++) hist[3'(k)] <= hist[3'(k + 1)];
      hist[7] <= new_w;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      key_ready  <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      num_rounds <= 4'd0;
      nk         <= 4'd4;
      i_idx      <= 6'd0;
      last_idx   <= 6'd0;
      i_mod      <= 3'd0;
      rcon       <= 8'h01;
      rd_key     <= 128'h0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (!req_ok) begin
              err <= 1'b1;
            end else begin
              nk         <= req_nk;
              num_rounds <= req_nk + 4'd6;
              i_idx      <= {2'b00, req_nk};
              last_idx   <= {req_nk, 2'b00} + 6'd27;  // 4*(Nr+1)-1
              i_mod      <= 3'd0;
              rcon       <= 8'h01;
              key_ready  <= 1'b0;
              busy       <= 1'b1;
              state      <= EXPAND;
            end
          end
        end
        EXPAND: begin
          i_idx <= i_idx + 6'd1;
          i_mod <= (i_mod == mod_last) ? 3'd0 : i_mod + 3'd1;
          if (i_mod == 3'd0)
            rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
          if (i_idx == last_idx) begin
            busy      <= 1'b0;
            key_ready <= 1'b1;
            done      <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (rd_round > num_rounds)
        rd_key <= 128'h0;
      else
        rd_key <= {store[rd_base], store[rd_base | 6'd1],
                   store[rd_base | 6'd2], store[rd_base | 6'd3]};
    end
  end
endmodule

// File: tb/tb_aes_key_schedule.sv
// Bench for aes_key_schedule: FIPS-197 vectors, random keys against a table-driven
// reference expansion, rejection, overlap, back-to-back and mid-expansion reset.

module tb_aes_key_schedule;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   key_len;
  logic [255:0] key_in;
  logic         busy, key_ready, done, err;
  logic [3:0]   num_rounds;
  logic [3:0]   rd_round;
  logic [127:0] rd_key;

  logic         s_start;
  logic [1:0]   s_key_len;
  logic [255:0] s_key_in;
  logic         s_busy, s_key_ready, s_done, s_err;
  logic [3:0]   s_num_rounds;
  logic [3:0]   s_rd_round;
  logic [127:0] s_rd_key;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sbox_tab [256];
  logic [127:0] model_rk [16];
  logic [127:0] got [16];

  localparam logic [255:0] K128 = 256'h2b7e151628aed2a6abf7158809cf4f3c << 128;
  localparam logic [255:0] K192 = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b << 64;
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  always #5 clk = ~clk;

  aes_key_schedule #(.MAX_KEY_BITS(256)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_len(key_len), .key_in(key_in),
    .busy(busy), .key_ready(key_ready), .done(done), .err(err),
    .num_rounds(num_rounds), .rd_round(rd_round), .rd_key(rd_key)
  );

  aes_key_schedule #(.MAX_KEY_BITS(128)) dut128 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .key_len(s_key_len), .key_in(s_key_in),
    .busy(s_busy), .key_ready(s_key_ready), .done(s_done), .err(s_err),
    .num_rounds(s_num_rounds), .rd_round(s_rd_round), .rd_key(s_rd_key)
  );

  // S-box table from the generator-3 walk over GF(2^8).
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    for (int n = 0; n < 255; n++) begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_tab[p] = x ^ 8'h63;
    end
    sbox_tab[0] = 8'h63;
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] t);
    return {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
  endfunction

  // Textbook expansion into a flat word array; rounds beyond Nr read as zero.
  task automatic build_model(input logic [255:0] key, input int len);
    logic [31:0] w [60];
    logic [7:0]  rcon_tab [10];
    logic [31:0] t;
    int nk, nr;
    rcon_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    nk = 4 + 2 * len;
    nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0)
        t = sub_word({t[23:0], t[31:24]}) ^ {rcon_tab[i/nk - 1], 24'h0};
      else if (nk == 8 && i % 8 == 4)
        t = sub_word(t);
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++)
      model_rk[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    for (int j = 0; j < 8; j++) k[32*j +: 32] = $urandom();
    return k;
  endfunction

  task automatic kick(input logic [255:0] key, input logic [1:0] len);
    @(negedge clk);
    start   = 1'b1;
    key_len = len;
    key_in  = key;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = -1;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        cyc = c;
        break;
      end
    end
  endtask

  task automatic read_all();
    for (int r = 0; r < 16; r++) begin
      @(negedge clk);
      rd_round = 4'(r);
      @(posedge clk);
      #1 got[r] = rd_key;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0; key_len = 2'b00; key_in = '0; rd_round = 4'd0;
    s_start = 1'b0; s_key_len = 2'b00; s_key_in = '0; s_rd_round = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks += 6;
    if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (key_ready !== 1'b0)  begin errors++; $display("FAIL reset_key_ready got=%b exp=0", key_ready); end
    if (done !== 1'b0)       begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    if (err !== 1'b0)        begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
    if (num_rounds !== 4'd0) begin errors++; $display("FAIL reset_num_rounds got=%0d exp=0", num_rounds); end
    if (rd_key !== 128'h0)   begin errors++; $display("FAIL reset_rd_key got=%h exp=0", rd_key); end
  endtask

  task automatic test_fips();
    logic [255:0] keys [3];
    logic [127:0] kv [3];
    int kr [3];
    int cyc, nk;
    keys = '{K128, K192, K256};
    kr   = '{10, 12, 14};
    kv   = '{128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 128'he98ba06f448c773c8ecc720401002202,
             128'hfe4890d1e6188d0b046df344706c631e};
    for (int v = 0; v < 3; v++) begin
      nk = 4 + 2 * v;
      build_model(keys[v], v);
      kick(keys[v], 2'(v));
      wait_done(80, cyc);
      checks += 4;
      if (cyc != 3 * nk + 28) begin errors++; $display("FAIL fips_latency len=%0d got=%0d exp=%0d", v, cyc, 3*nk+28); end
      if (num_rounds !== 4'(kr[v])) begin errors++; $display("FAIL fips_num_rounds len=%0d got=%0d exp=%0d", v, num_rounds, kr[v]); end
      if (key_ready !== 1'b1) begin errors++; $display("FAIL fips_key_ready len=%0d got=%b exp=1", v, key_ready); end
      @(posedge clk);
      #1;
      if (done !== 1'b0) begin errors++; $display("FAIL fips_done_pulse len=%0d got=%b exp=0", v, done); end
      read_all();
      checks++;
      if (got[kr[v]] !== kv[v]) begin errors++; $display("FAIL fips_last_round len=%0d got=%h exp=%h", v, got[kr[v]], kv[v]); end
      if (v == 0) begin
        checks++;
        if (got[1] !== 128'ha0fafe1788542cb123a339392a6c7605)
          begin errors++; $display("FAIL fips_round1 got=%h exp=a0fafe1788542cb123a339392a6c7605", got[1]); end
      end
      for (int r = 0; r < 16; r++) begin
        checks++;
        if (got[r] !== model_rk[r]) begin errors++; $display("FAIL fips_schedule len=%0d r=%0d got=%h exp=%h", v, r, got[r], model_rk[r]); end
      end
    end
  endtask

  task automatic test_random();
    logic [255:0] k;
    int len, cyc;
    for (int n = 0; n < 5; n++) begin
      k   = rand_key();
      len = $urandom_range(0, 2);
      build_model(k, len);
      kick(k, 2'(len));
      wait_done(80, cyc);
      checks++;
      if (cyc != 6 * len + 40) begin errors++; $display("FAIL rand_latency len=%0d got=%0d exp=%0d", len, cyc, 6*len+40); end
      read_all();
      for (int r = 0; r < 16; r++) begin
        checks++;
        if (got[r] !== model_rk[r]) begin errors++; $display("FAIL rand_schedule len=%0d r=%0d got=%h exp=%h", len, r, got[r], model_rk[r]); end
      end
    end
  endtask

  task automatic test_reject();
    int cyc;
    // The last loaded schedule (model_rk) must survive a reserved-length request.
    kick(rand_key(), 2'b11);
    checks += 4;
    if (err !== 1'b1)       begin errors++; $display("FAIL rej_err got=%b exp=1", err); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL rej_busy got=%b exp=0", busy); end
    if (key_ready !== 1'b1) begin errors++; $display("FAIL rej_key_ready got=%b exp=1", key_ready); end
    @(posedge clk);
    #1;
    if (err !== 1'b0)       begin errors++; $display("FAIL rej_err_width got=%b exp=0", err); end
    read_all();
    for (int r = 0; r < 16; r++) begin
      checks++;
      if (got[r] !== model_rk[r]) begin errors++; $display("FAIL rej_retained r=%0d got=%h exp=%h", r, got[r], model_rk[r]); end
    end

    // Narrow instance: load AES-128, then reject 256 and 192.
    @(negedge clk);
    s_start = 1'b1; s_key_len = 2'b00; s_key_in = K128;
    @(posedge clk);
    #1 s_start = 1'b0;
    cyc = -1;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk);
      #1;
      if (s_done) begin cyc = c; break; end
    end
    checks++;
    if (cyc != 40) begin errors++; $display("FAIL narrow_latency got=%0d exp=40", cyc); end
    for (int l = 2; l >= 1; l--) begin
      @(negedge clk);
      s_start = 1'b1; s_key_len = 2'(l); s_key_in = rand_key();
      @(posedge clk);
      #1 s_start = 1'b0;
      checks += 4;
      if (s_err !== 1'b1)       begin errors++; $display("FAIL narrow_err len=%0d got=%b exp=1", l, s_err); end
      if (s_busy !== 1'b0)      begin errors++; $display("FAIL narrow_busy len=%0d got=%b exp=0", l, s_busy); end
      if (s_key_ready !== 1'b1) begin errors++; $display("FAIL narrow_key_ready len=%0d got=%b exp=1", l, s_key_ready); end
      @(posedge clk);
      #1;
      if (s_err !== 1'b0)       begin errors++; $display("FAIL narrow_err_width len=%0d got=%b exp=0", l, s_err); end
    end
    build_model(K128, 0);
    for (int r = 0; r < 12; r++) begin
      @(negedge clk);
      s_rd_round = 4'(r);
      @(posedge clk);
      #1;
      checks++;
      if (s_rd_key !== model_rk[r]) begin errors++; $display("FAIL narrow_schedule r=%0d got=%h exp=%h", r, s_rd_key, model_rk[r]); end
    end
    checks++;
    if (s_num_rounds !== 4'd10) begin errors++; $display("FAIL narrow_num_rounds got=%0d exp=10", s_num_rounds); end
  endtask

  task automatic test_start_during_expand();
    logic [255:0] k;
    int len, cyc, err_seen;
    k   = rand_key();
    len = $urandom_range(0, 2);
    build_model(k, len);
    kick(k, 2'(len));
    cyc = -1;
    err_seen = 0;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk);
      #1;
      if (err) err_seen++;
      if (c == 20) begin
        start = 1'b1; key_in = rand_key(); key_len = 2'($urandom_range(0, 2));
      end
      if (c == 21) start = 1'b0;
      if (done) begin cyc = c; break; end
    end
    checks += 2;
    if (cyc != 6 * len + 40) begin errors++; $display("FAIL overlap_latency len=%0d got=%0d exp=%0d", len, cyc, 6*len+40); end
    if (err_seen != 0)       begin errors++; $display("FAIL overlap_err got=%0d exp=0", err_seen); end
    read_all();
    for (int r = 0; r < 16; r++) begin
      checks++;
      if (got[r] !== model_rk[r]) begin errors++; $display("FAIL overlap_schedule r=%0d got=%h exp=%h", r, got[r], model_rk[r]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] ka, kb;
    int la, lb, cyc;
    ka = rand_key(); la = $urandom_range(0, 2);
    kb = rand_key(); lb = $urandom_range(0, 2);
    kick(ka, 2'(la));
    wait_done(80, cyc);
    checks++;
    if (cyc != 6 * la + 40) begin errors++; $display("FAIL b2b_first_latency got=%0d exp=%0d", cyc, 6*la+40); end
    // Still inside the done cycle: this start is sampled by the next edge.
    start = 1'b1; key_in = kb; key_len = 2'(lb);
    @(posedge clk);
    #1 start = 1'b0;
    checks += 3;
    if (key_ready !== 1'b0) begin errors++; $display("FAIL b2b_key_ready got=%b exp=0", key_ready); end
    if (busy !== 1'b1)      begin errors++; $display("FAIL b2b_busy got=%b exp=1", busy); end
    if (err !== 1'b0)       begin errors++; $display("FAIL b2b_err got=%b exp=0", err); end
    wait_done(80, cyc);
    checks++;
    if (cyc != 6 * lb + 40) begin errors++; $display("FAIL b2b_second_latency got=%0d exp=%0d", cyc, 6*lb+40); end
    build_model(kb, lb);
    read_all();
    for (int r = 0; r < 16; r++) begin
      checks++;
      if (got[r] !== model_rk[r]) begin errors++; $display("FAIL b2b_schedule r=%0d got=%h exp=%h", r, got[r], model_rk[r]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [255:0] k;
    int cyc;
    rd_round = 4'd0;
    kick(rand_key(), 2'b10);
    repeat (25) @(posedge clk);
    #1;
    checks++;
    if (rd_key === 128'h0) begin errors++; $display("FAIL midrst_pre_rd_key got=%h exp=nonzero", rd_key); end
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (busy !== 1'b0)       begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    if (key_ready !== 1'b0)  begin errors++; $display("FAIL midrst_key_ready got=%b exp=0", key_ready); end
    if (rd_key !== 128'h0)   begin errors++; $display("FAIL midrst_rd_key got=%h exp=0", rd_key); end
    if (num_rounds !== 4'd0) begin errors++; $display("FAIL midrst_num_rounds got=%0d exp=0", num_rounds); end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (key_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_idle ready=%b busy=%b exp=0,0", key_ready, busy); end
    k = rand_key();
    build_model(k, 2);
    kick(k, 2'b10);
    wait_done(80, cyc);
    checks++;
    if (cyc != 52) begin errors++; $display("FAIL midrst_reload_latency got=%0d exp=52", cyc); end
    read_all();
    for (int r = 0; r < 16; r++) begin
      checks++;
      if (got[r] !== model_rk[r]) begin errors++; $display("FAIL midrst_schedule r=%0d got=%h exp=%h", r, got[r], model_rk[r]); end
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips();
    test_random();
    test_reject();
    test_start_during_expand();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/aes_key_schedule.md
# aes_key_schedule

Sequential, parametrised AES key schedule supporting AES-128, AES-192 and AES-256, selected at run time per key load. It expands the cipher key into all round keys, generating one 32-bit word per clock into an internal round-key store. The store has a registered random-access read port that the round datapath indexes by round number. It supersedes the single-round combinational expansion step, so the cipher core no longer recomputes keys on the fly.

## Interface
- MAX_KEY_BITS, 256, largest supported key size: 128, 192 or 256. Store depth is 44, 52 or 60 words respectively.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle load request, honoured only while idle.
- key_len  in  2  key size: 00 = 128, 01 = 192, 10 = 256, 11 = reserved.
- key_in  in  256  cipher key, MSB-aligned. w0 = key_in[255:224]. Unused low bits are ignored.
- busy  out  1  expansion in progress.
- key_ready  out  1  level signal: a complete schedule is held in the store.
- done  out  1  one-cycle pulse when expansion completes.
- err  out  1  one-cycle pulse when a start is rejected.
- num_rounds  out  4  Nr of the current schedule: 10, 12 or 14.
- rd_round  in  4  round-key index to read.
- rd_key  out  128  registered round key: words 4r..4r+3, word 4r in [127:96].

## Operation
- Decided: one clock; reset is asynchronous and active-low.
- States: IDLE and EXPAND.

IDLE, on start:
- If key_len = 11, or the requested size exceeds MAX_KEY_BITS: pulse err and stay in IDLE. The store, key_ready and num_rounds are unchanged.
- Otherwise: write words w0..w(Nk-1) from key_in into the store and the history window. Nk is 4, 6 or 8.
- Latch Nk and Nr; set rcon to 0x01 and i to Nk.
- Clear key_ready, set busy, enter EXPAND.

EXPAND, one word per cycle:
- temp = w[i-1].
- If i mod Nk = 0: temp = SubWord(RotWord(temp)) ^ {rcon, 24'h0}, then rcon = xtime(rcon), i.e. {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 0).
- Else if Nk = 8 and i mod 8 = 4: temp = SubWord(temp).
- w[i] = w[i-Nk] ^ temp. Write it to the store and shift it into the history window.
- The history window is an 8-word shift register holding w[i-8..i-1]. w[i-Nk] is selected by Nk.
- SubWord uses four instances of the existing s_box module (a_key input, c_key output).
- Track i mod Nk with a counter that wraps at Nk, not with a divider.
- After writing word 4*(Nr+1)-1 (43, 51 or 59): clear busy, set key_ready, pulse done, return to IDLE.

Reads:
- rd_key <= store[4*rd_round .. 4*rd_round+3] on every clock, in any state.
- If rd_round > Nr: rd_key <= 0.
- Reads during EXPAND return partially written contents. The consumer must gate its reads on key_ready.

## Timing
- Reset values: busy = 0, key_ready = 0, done = 0, err = 0, num_rounds = 0, rd_key = 0, state = IDLE. Store contents are not reset and are don't-care.
- Start is sampled at edge T0. Word Nk is written at edge T1 and the final word at edge T(4Nr+4-Nk).
- done and key_ready go high after that final edge: T40 for AES-128, T46 for AES-192, T52 for AES-256.
- err goes high for exactly the cycle after the rejecting edge.
- start while busy is ignored: no err, and the expansion continues undisturbed.
- A start in the same cycle that done is high is accepted, because the block is already IDLE. key_ready drops on the following edge.
- rd_key latency is 1 cycle: rd_round set before edge Tn gives data valid after Tn.
- rst_n low mid-expansion: all outputs clear immediately and asynchronously. The partial schedule is discarded and key_ready stays 0 until the next completed load.
- rcon sequence: AES-128 reaches 0x36 at i = 40. AES-192 ends at 0x80 (i = 48). AES-256 ends at 0x40 (i = 56).

## Test plan
- AES-128, FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c -> done 40 cycles after start. rd_round = 1 gives a0fafe1788542cb123a339392a6c7605. rd_round = 10 gives d014f9a8c9ee2589e13f0cc8b6630ca6. num_rounds = 10.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> done after 46 cycles. rd_round = 12 gives e98ba06f448c773c8ecc720401002202.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> done after 52 cycles. rd_round = 14 gives fe4890d1e6188d0b046df344706c631e. rd_round = 15 gives 0.
- key_len = 11, and key_len = 10 with MAX_KEY_BITS = 128 -> err pulse of one cycle, busy stays 0, the previous key_ready and schedule are retained.
- Start during EXPAND at cycle 20 -> ignored, and the schedule matches the first key. Start coincident with done -> the new load is accepted and key_ready falls.
- rst_n low at cycle 25 of an AES-256 expansion -> busy, key_ready and rd_key read 0 immediately. A reload after reset produces the correct schedule.
